// File: rtl/rr_arb_8.sv
// Eight-way round-robin arbiter with a per-grant hold limit.
// Grants are registered and presented both one-hot and as a 3-bit decoder index.
module rr_arb_8 #(
  parameter logic [15:0] HOLD_MAX = 16'd16
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  localparam logic [15:0] LAST = HOLD_MAX - 16'd1;

  state_t      state;
  logic [2:0]  ptr;
  logic [15:0] cnt;
  logic [2:0]  sel;

  // First requester at or after ptr, wrapping modulo 8.
  always_comb begin
    logic       found;
    logic [2:0] idx;
    sel   = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + i[2:0];
      if (req[idx] && !found) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state   <= IDLE;
      ptr     <= 3'd0;
      cnt     <= 16'd0;
      gnt     <= 8'h00;
      gnt_idx <= 3'd0;
      gnt_vld <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|req) begin
            gnt     <= 8'd1 << sel;
            gnt_idx <= sel;
            gnt_vld <= 1'b1;
            cnt     <= 16'd0;
            state   <= GRANT;
          end
        end
        GRANT: begin
          // A release on the limit cycle is a normal release, not a timeout.
          if (!req[gnt_idx]) begin
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            ptr     <= gnt_idx + 3'd1;
            state   <= IDLE;
          end else if (cnt == LAST) begin
            gnt     <= 8'h00;
            gnt_vld <= 1'b0;
            timeout <= 1'b1;
            ptr     <= gnt_idx + 3'd1;
            state   <= IDLE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arb_8.sv
// Directed bench for rr_arb_8: default-limit instance plus a HOLD_MAX=4 instance.
module tb_rr_arb_8;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic [7:0] gnt_a, gnt_b;
  logic [2:0] idx_a, idx_b;
  logic       vld_a, vld_b;
  logic       to_a, to_b;

  int vectors;
  int miscompares;

  rr_arb_8 dut_a (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req_a),
    .gnt(gnt_a), .gnt_idx(idx_a), .gnt_vld(vld_a), .timeout(to_a)
  );

  rr_arb_8 #(.HOLD_MAX(16'd4)) dut_b (
    .sys_clk(clk), .sys_rst_n(rst_n), .req(req_b),
    .gnt(gnt_b), .gnt_idx(idx_b), .gnt_vld(vld_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [2:0] order [5];
    logic [7:0] one;
    vectors     = 0;
    miscompares = 0;
    order       = '{3'd0, 3'd4, 3'd7, 3'd0, 3'd4};

    // Reset held with everyone requesting.
    rst_n = 1'b0;
    req_a = 8'hFF;
    req_b = 8'h00;
    #1;
    check("rst_gnt", 16'(gnt_a), 16'h00);
    check("rst_idx", 16'(idx_a), 16'd0);
    check("rst_vld", 16'(vld_a), 16'd0);
    check("rst_to",  16'(to_a),  16'd0);
    tick();
    tick();
    check("rst_hold_gnt", 16'(gnt_a), 16'h00);
    rst_n = 1'b1;
    tick();
    check("first_gnt", 16'(gnt_a), 16'h01);
    check("first_idx", 16'(idx_a), 16'd0);
    check("first_vld", 16'(vld_a), 16'd1);
    req_a = 8'h00;
    tick();
    check("rel0_gnt", 16'(gnt_a), 16'h00);
    tick();

    // Single requester 5 for five cycles, then release.
    req_a = 8'h20;
    for (int c = 0; c < 5; c++) begin
      tick();
      check("single_gnt", 16'(gnt_a), 16'h20);
      check("single_idx", 16'(idx_a), 16'd5);
      check("single_to",  16'(to_a),  16'd0);
    end
    req_a = 8'h00;
    tick();
    check("single_rel_gnt", 16'(gnt_a), 16'h00);
    check("single_rel_vld", 16'(vld_a), 16'd0);
    check("single_rel_idx", 16'(idx_a), 16'd5);
    check("single_rel_to",  16'(to_a),  16'd0);
    tick();
    check("idle_idx_keep", 16'(idx_a), 16'd5);

    // Wrap-around: after serving 7 the pointer is 0, so 0 beats 7.
    req_a = 8'h80;
    tick();
    check("wrap_g7", 16'(gnt_a), 16'h80);
    req_a = 8'h00;
    tick();
    check("wrap_rel", 16'(gnt_a), 16'h00);
    req_a = 8'h81;
    tick();
    check("wrap_next", 16'(gnt_a), 16'h01);
    check("wrap_idx",  16'(idx_a), 16'd0);
    req_a = 8'h00;
    tick();
    tick();

    // Mid-grant reset on idx 3, then ptr must restart at 0.
    req_a = 8'h08;
    tick();
    check("mid_gnt3", 16'(gnt_a), 16'h08);
    tick();
    rst_n = 1'b0;
    #1;
    check("mid_rst_gnt", 16'(gnt_a), 16'h00);
    check("mid_rst_vld", 16'(vld_a), 16'd0);
    check("mid_rst_to",  16'(to_a),  16'd0);
    req_a = 8'h0C;
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_gnt", 16'(gnt_a), 16'h04);
    check("post_rst_idx", 16'(idx_a), 16'd2);
    req_a = 8'h00;

    // Rotation with HOLD_MAX=4: 4 grant cycles, then a gap with a timeout pulse.
    req_b = 8'h91;
    for (int g = 0; g < 5; g++) begin
      one = 8'd1 << order[g];
      for (int c = 0; c < 4; c++) begin
        tick();
        check("rot_gnt", 16'(gnt_b), 16'(one));
        check("rot_to",  16'(to_b),  16'd0);
      end
      tick();
      check("rot_gap_gnt", 16'(gnt_b), 16'h00);
      check("rot_gap_to",  16'(to_b),  16'd1);
      check("rot_gap_idx", 16'(idx_b), 16'(order[g]));
    end

    // Release exactly on the limit cycle: no timeout pulse.
    tick();
    check("sim_gnt7", 16'(gnt_b), 16'h80);
    tick();
    tick();
    tick();
    check("sim_still7", 16'(gnt_b), 16'h80);
    req_b = 8'h11;
    tick();
    check("sim_rel_gnt", 16'(gnt_b), 16'h00);
    check("sim_rel_vld", 16'(vld_b), 16'd0);
    check("sim_rel_to",  16'(to_b),  16'd0);
    tick();
    check("sim_next", 16'(gnt_b), 16'h01);
    check("sim_next_to", 16'(to_b), 16'd0);
    req_b = 8'h00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
